seq_left_shifter: RTL and testbench

- Multi-cycle left shifter that shifts one bit position per clock. It supports logical, arithmetic (with overflow detection) and rotate modes.
- Companion to the team's combinational right shifter. It covers the opposite shift direction for datapaths where area matters more than latency.
- Operands enter through a valid/ready input handshake. Results leave through a valid/ready output handshake with backpressure.

---
 rtl/shift_pkg.sv | 17 +
 rtl/left_shift_step.sv | 34 +++
 rtl/seq_left_shifter.sv | 119 +++++++++++
 tb/tb_seq_left_shifter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shifter family: mode encodings and FSM state
// encoding. Intended to be imported by both the sequential left shifter and
// the combinational right shifter.
package shift_pkg;

    // Shift mode encodings (2'b11 is reserved and behaves as logical)
    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_ASL = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/left_shift_step.sv
// Combinational single-bit left-shift step.
// Ports:
//   value     - current working value
//   mode      - shift mode (LSL / ASL / ROL, reserved treated as LSL)
//   ovf_in    - accumulated overflow so far
//   value_nxt - value after one step
//   carry     - bit shifted out of the MSB by this step
//   ovf_nxt   - accumulated overflow after this step (only ASL accumulates)
module left_shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       mode,
    input  logic             ovf_in,
    output logic [WIDTH-1:0] value_nxt,
    output logic             carry,
    output logic             ovf_nxt
);

    always_comb begin
        value_nxt = {value[WIDTH-2:0], 1'b0};
        carry     = value[WIDTH-1];
        ovf_nxt   = ovf_in;
        case (mode)
            MODE_ROL: value_nxt = {value[WIDTH-2:0], value[WIDTH-1]};
            // Sign changes on this step when the two top bits differ.
            MODE_ASL: ovf_nxt = ovf_in | (value[WIDTH-1] ^ value[WIDTH-2]);
            default:  ;
        endcase
    end

endmodule

// File: rtl/seq_left_shifter.sv
// Multi-cycle left shifter: one bit position per clock, logical, arithmetic
// (with overflow detection) and rotate modes.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake (ready only while idle)
//   data_in, shift, mode  - operand, shift amount, mode
//   out_valid / out_ready - result handshake with backpressure
//   data_out, carry_out, overflow - result; held between operations,
//                           qualified only by out_valid
module seq_left_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             overflow
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work;
    logic [1:0]       work_mode;
    logic             work_ovf;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] step_value;
    logic             step_carry;
    logic             step_ovf;

    wire last_step = (cnt == SHW'(1));

    left_shift_step #(.WIDTH(WIDTH)) u_step (
        .value     (work),
        .mode      (work_mode),
        .ovf_in    (work_ovf),
        .value_nxt (step_value),
        .carry     (step_carry),
        .ovf_nxt   (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (shift == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_step) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The working register is separate from the result registers so that
    // data_out keeps the previous result while a new operand is shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            work_mode <= MODE_LSL;
            work_ovf  <= 1'b0;
            cnt       <= '0;
            data_out  <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work      <= data_in;
                        work_mode <= mode;
                        work_ovf  <= 1'b0;
                        cnt       <= shift;
                        // Zero shift skips SHIFT entirely; publish the operand now.
                        if (shift == '0) begin
                            data_out  <= data_in;
                            carry_out <= 1'b0;
                            overflow  <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    work     <= step_value;
                    work_ovf <= step_ovf;
                    cnt      <= cnt - SHW'(1);
                    if (last_step) begin
                        data_out  <= step_value;
                        carry_out <= step_carry;
                        overflow  <= step_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_left_shifter.sv
module tb_seq_left_shifter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       iv8, ir8, ov8, or8, co8, of8;
    logic [7:0] d8, q8;
    logic [2:0] s8;
    logic [1:0] m8;

    // WIDTH=16 instance
    logic        iv16, ir16, ov16, or16, co16, of16;
    logic [15:0] d16, q16;
    logic [3:0]  s16;
    logic [1:0]  m16;

    seq_left_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .data_in(d8), .shift(s8), .mode(m8),
        .out_valid(ov8), .out_ready(or8), .data_out(q8),
        .carry_out(co8), .overflow(of8)
    );

    seq_left_shifter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16), .data_in(d16), .shift(s16), .mode(m16),
        .out_valid(ov16), .out_ready(or16), .data_out(q16),
        .carry_out(co16), .overflow(of16)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: closed-form shift of the whole operand rather than stepping.
    // Arithmetic overflow = the top shift+1 bits of the operand are not all equal.
    function automatic exp_t model(input int w, input logic [15:0] d, input int sh,
                                   input logic [1:0] m);
        exp_t        r;
        logic [31:0] x, mask, top, tmask;
        mask   = (32'd1 << w) - 32'd1;
        x      = {16'd0, d} & mask;
        r.carry = (sh == 0) ? 1'b0 : x[w - sh];
        if (m == 2'b10) r.data = 16'(((x << sh) | (x >> (w - sh))) & mask);
        else            r.data = 16'((x << sh) & mask);
        r.ovf = 1'b0;
        if (m == 2'b01 && sh > 0) begin
            top   = x >> (w - 1 - sh);
            tmask = (32'd1 << (sh + 1)) - 32'd1;
            r.ovf = !(top == 32'd0 || top == tmask);
        end
        return r;
    endfunction

    // Output monitor: every completed output handshake is checked in order.
    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            exp_t e;
            if (sb8.size() == 0) chk("w8 unexpected output", 32'd1, 32'd0);
            else begin
                e = sb8.pop_front();
                chk("w8 data_out", 32'(q8), 32'(e.data));
                chk("w8 carry_out", 32'(co8), 32'(e.carry));
                chk("w8 overflow", 32'(of8), 32'(e.ovf));
            end
        end
        if (!rst && ov16 && or16) begin
            exp_t e;
            if (sb16.size() == 0) chk("w16 unexpected output", 32'd1, 32'd0);
            else begin
                e = sb16.pop_front();
                chk("w16 data_out", 32'(q16), 32'(e.data));
                chk("w16 carry_out", 32'(co16), 32'(e.carry));
                chk("w16 overflow", 32'(of16), 32'(e.ovf));
            end
        end
    end

    // Random out_ready pattern during the randomised phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                or8  = 1'($urandom_range(0, 1));
                or16 = 1'($urandom_range(0, 1));
            end
        end
    end

    // Present an operand (called at posedge+1), hold until accepted, push expectation.
    task automatic drive(input int w, input logic [15:0] d, input int sh, input logic [1:0] m);
        exp_t e;
        bit   acc;
        int   n;
        e = model(w, d, sh, m);
        if (w == 8) begin iv8 = 1'b1; d8 = d[7:0]; s8 = 3'(sh); m8 = m; end
        else        begin iv16 = 1'b1; d16 = d; s16 = 4'(sh); m16 = m; end
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = (w == 8) ? ir8 : ir16;
            @(posedge clk);
            n++;
        end
        #1;
        // Scramble the idle inputs; the DUT must ignore them while busy.
        if (w == 8) begin iv8 = 1'b0; d8 = 8'($urandom); s8 = 3'($urandom); m8 = 2'($urandom); end
        else        begin iv16 = 1'b0; d16 = 16'($urandom); s16 = 4'($urandom); m16 = 2'($urandom); end
        if (!acc) chk("accept timeout", 32'd0, 32'd1);
        else if (w == 8) sb8.push_back(e);
        else             sb16.push_back(e);
    endtask

    // Directed WIDTH=8 op with out_ready=1; checks cycles from accept to out_valid.
    task automatic dir(input logic [7:0] d, input int sh, input logic [1:0] m,
                       input int lat, input string tag);
        int n;
        drive(8, {8'd0, d}, sh, m);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ov8) break;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        iv8 = 1'b0; d8 = '0; s8 = '0; m8 = '0; or8 = 1'b1;
        iv16 = 1'b0; d16 = '0; s16 = '0; m16 = '0; or16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset in_ready", 32'(ir8), 32'd1);
        chk("reset out_valid", 32'(ov8), 32'd0);
        chk("reset data_out", 32'(q8), 32'd0);
        chk("reset carry_out", 32'(co8), 32'd0);
        chk("reset overflow", 32'(of8), 32'd0);
        chk("reset w16 data_out", 32'(q16), 32'd0);
        @(posedge clk);
        #1;

        dir(8'h81, 1, 2'b00, 2, "lsl 81<<1");
        dir(8'h40, 1, 2'b01, 2, "asl 40<<1");
        dir(8'hF0, 3, 2'b01, 4, "asl F0<<3");
        dir(8'h81, 3, 2'b10, 4, "rol 81<<3");
        dir(8'hA5, 0, 2'b10, 1, "rol A5<<0");
        dir(8'h5A, 2, 2'b11, 3, "reserved 5A<<2");
        dir(8'hC3, 7, 2'b01, 8, "asl C3<<7");

        // Backpressure: result held, second operand ignored while in DONE.
        or8 = 1'b0;
        drive(8, 16'h0001, 7, 2'b00);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ov8) break;
        end
        chk("bp latency", 32'(n), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin iv8 = 1'b1; d8 = 8'h55; s8 = 3'd1; m8 = 2'b00; end
            if (i == 3) iv8 = 1'b0;
            @(negedge clk);
            chk("bp data_out held", 32'(q8), 32'h80);
            chk("bp in_ready", 32'(ir8), 32'd0);
            chk("bp out_valid", 32'(ov8), 32'd1);
        end
        @(posedge clk);
        #1 or8 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp in_ready after", 32'(ir8), 32'd1);
        chk("bp no extra output", 32'(ov8), 32'd0);
        @(posedge clk);
        #1;

        // Reset during the third SHIFT cycle drops the transaction.
        drive(8, 16'h00FF, 7, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sb8.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid reset in_ready", 32'(ir8), 32'd1);
        chk("mid reset out_valid", 32'(ov8), 32'd0);
        chk("mid reset data_out", 32'(q8), 32'd0);
        @(posedge clk);
        #1;
        dir(8'h03, 2, 2'b00, 3, "post reset 03<<2");

        // Randomised: WIDTH=8 then WIDTH=16, random out_ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            drive(8, 16'($urandom), int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            drive(16, 16'($urandom), int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end

        rand_rdy = 1'b0;
        @(posedge clk);
        #1 begin or8 = 1'b1; or16 = 1'b1; end
        n = 0;
        while ((sb8.size() != 0 || sb16.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain w8", 32'(sb8.size()), 32'd0);
        chk("drain w16", 32'(sb16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
